// File: rtl/axi4lite_fifo_bridge.sv
// AXI4-Lite slave that turns writes into pushes onto a push FIFO and reads into pops from a pop FIFO.
// A reserved read address returns FIFO status without popping.
`timescale 1ns/1ps

// state    | meaning
// W_IDLE   | collecting AW and W beats, each ready held until its beat is taken
// W_PUSH   | both beats held, waiting for room in the push FIFO
// W_RESP   | write response offered until bready
// R_IDLE   | arready high, waiting for a read address
// R_DECODE | status read, pop, stall on empty, or error response
// R_WAIT   | pop issued, capture pop data the cycle after read_en
// R_RESP   | read response offered until rready
module axi4lite_fifo_bridge #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] STATUS_ADDR    = ADDR_W'(32'hFFFF_FFF0),
    parameter bit                BLOCK_ON_FULL  = 1'b1,
    parameter bit                BLOCK_ON_EMPTY = 1'b1
) (
    input  logic                     clk,
    input  logic                     arestn,
    input  logic [ADDR_W-1:0]        araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    output logic                     read_en,
    input  logic [DATA_W-1:0]        read_data,
    input  logic                     empty,
    output logic                     write_en,
    output logic [ADDR_W+DATA_W-1:0] write_data,
    input  logic                     full
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DECODE, R_WAIT, R_RESP} r_state_t;

    w_state_t                  w_state, w_state_n;
    logic                      aw_got, aw_got_n;
    logic                      w_got, w_got_n;
    logic [ADDR_W-1:0]         aw_q, aw_q_n;
    logic [DATA_W-1:0]         w_q, w_q_n;
    logic                      awready_n, wready_n, write_en_n, bvalid_n;
    logic [1:0]                bresp_n;
    logic [ADDR_W+DATA_W-1:0]  write_data_n;

    r_state_t                  r_state, r_state_n;
    logic [ADDR_W-1:0]         ar_q, ar_q_n;
    logic                      arready_n, read_en_n, rvalid_n;
    logic [DATA_W-1:0]         rdata_n;
    logic [1:0]                rresp_n;

    always_ff @(posedge clk or negedge arestn) begin
        if (!arestn) begin
            w_state    <= W_IDLE;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_q       <= '0;
            w_q        <= '0;
            awready    <= 1'b0;
            wready     <= 1'b0;
            write_en   <= 1'b0;
            write_data <= '0;
            bvalid     <= 1'b0;
            bresp      <= 2'b00;
        end else begin
            w_state    <= w_state_n;
            aw_got     <= aw_got_n;
            w_got      <= w_got_n;
            aw_q       <= aw_q_n;
            w_q        <= w_q_n;
            awready    <= awready_n;
            wready     <= wready_n;
            write_en   <= write_en_n;
            write_data <= write_data_n;
            bvalid     <= bvalid_n;
            bresp      <= bresp_n;
        end
    end

    always_comb begin
        w_state_n    = w_state;
        aw_got_n     = aw_got;
        w_got_n      = w_got;
        aw_q_n       = aw_q;
        w_q_n        = w_q;
        awready_n    = awready;
        wready_n     = wready;
        write_en_n   = 1'b0;
        write_data_n = write_data;
        bvalid_n     = bvalid;
        bresp_n      = bresp;
        case (w_state)
            W_IDLE: begin
                if (awvalid && awready) begin
                    aw_q_n   = awaddr;
                    aw_got_n = 1'b1;
                end
                if (wvalid && wready) begin
                    w_q_n   = wdata;
                    w_got_n = 1'b1;
                end
                // ready is the inverse of "beat held", so it also rises on the first cycle out of reset
                awready_n = !aw_got_n;
                wready_n  = !w_got_n;
                if (aw_got_n && w_got_n) begin
                    w_state_n = W_PUSH;
                end
            end
            W_PUSH: begin
                if (!full) begin
                    write_en_n   = 1'b1;
                    write_data_n = {aw_q, w_q};
                    bresp_n      = RESP_OKAY;
                    w_state_n    = W_RESP;
                end else if (!BLOCK_ON_FULL) begin
                    bresp_n   = RESP_SLVERR;
                    w_state_n = W_RESP;
                end
            end
            W_RESP: begin
                // bvalid rises one cycle after the push strobe and holds until accepted
                if (bvalid && bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    aw_got_n  = 1'b0;
                    w_got_n   = 1'b0;
                    w_state_n = W_IDLE;
                end else begin
                    bvalid_n = 1'b1;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arestn) begin
        if (!arestn) begin
            r_state <= R_IDLE;
            ar_q    <= '0;
            arready <= 1'b0;
            read_en <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            r_state <= r_state_n;
            ar_q    <= ar_q_n;
            arready <= arready_n;
            read_en <= read_en_n;
            rvalid  <= rvalid_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
        end
    end

    always_comb begin
        r_state_n = r_state;
        ar_q_n    = ar_q;
        arready_n = arready;
        read_en_n = 1'b0;
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        case (r_state)
            R_IDLE: begin
                if (arvalid && arready) begin
                    ar_q_n    = araddr;
                    arready_n = 1'b0;
                    r_state_n = R_DECODE;
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_DECODE: begin
                if (ar_q == STATUS_ADDR) begin
                    rdata_n   = DATA_W'({full, empty});
                    rresp_n   = RESP_OKAY;
                    rvalid_n  = 1'b1;
                    r_state_n = R_RESP;
                end else if (!empty) begin
                    read_en_n = 1'b1;
                    r_state_n = R_WAIT;
                end else if (!BLOCK_ON_EMPTY) begin
                    rdata_n   = '0;
                    rresp_n   = RESP_SLVERR;
                    rvalid_n  = 1'b1;
                    r_state_n = R_RESP;
                end
            end
            R_WAIT: begin
                // first R_WAIT cycle is the strobe cycle; pop data appears in the next one
                if (!read_en) begin
                    rdata_n   = read_data;
                    rresp_n   = RESP_OKAY;
                    rvalid_n  = 1'b1;
                    r_state_n = R_RESP;
                end
            end
            R_RESP: begin
                if (rvalid && rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4lite_fifo_bridge.sv
// Randomised bench for axi4lite_fifo_bridge: a blocking and an error-policy instance share stimulus,
// one is selected per scenario and compared against queue-based expectations.
`timescale 1ns/1ps

module tb_axi4lite_fifo_bridge;

    localparam logic [31:0] STATUS = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        arestn = 1'b0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, read_data = '0;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        empty = 1'b1, full = 1'b0;
    bit          sel = 1'b0;

    logic        b_arready, b_rvalid, b_awready, b_wready, b_bvalid, b_read_en, b_write_en;
    logic [31:0] b_rdata;
    logic [1:0]  b_rresp, b_bresp;
    logic [63:0] b_write_data;
    logic        e_arready, e_rvalid, e_awready, e_wready, e_bvalid, e_read_en, e_write_en;
    logic [31:0] e_rdata;
    logic [1:0]  e_rresp, e_bresp;
    logic [63:0] e_write_data;

    always #5 clk = ~clk;

    axi4lite_fifo_bridge #(.ADDR_W(32), .DATA_W(32), .STATUS_ADDR(STATUS),
                           .BLOCK_ON_FULL(1'b1), .BLOCK_ON_EMPTY(1'b1)) u_blk (
        .clk(clk), .arestn(arestn), .araddr(araddr), .arvalid(arvalid), .arready(b_arready),
        .rdata(b_rdata), .rresp(b_rresp), .rvalid(b_rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(b_awready), .wdata(wdata), .wvalid(wvalid),
        .wready(b_wready), .bresp(b_bresp), .bvalid(b_bvalid), .bready(bready),
        .read_en(b_read_en), .read_data(read_data), .empty(empty),
        .write_en(b_write_en), .write_data(b_write_data), .full(full));

    axi4lite_fifo_bridge #(.ADDR_W(32), .DATA_W(32), .STATUS_ADDR(STATUS),
                           .BLOCK_ON_FULL(1'b0), .BLOCK_ON_EMPTY(1'b0)) u_err (
        .clk(clk), .arestn(arestn), .araddr(araddr), .arvalid(arvalid), .arready(e_arready),
        .rdata(e_rdata), .rresp(e_rresp), .rvalid(e_rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(e_awready), .wdata(wdata), .wvalid(wvalid),
        .wready(e_wready), .bresp(e_bresp), .bvalid(e_bvalid), .bready(bready),
        .read_en(e_read_en), .read_data(read_data), .empty(empty),
        .write_en(e_write_en), .write_data(e_write_data), .full(full));

    logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid, m_read_en, m_write_en;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp, m_bresp;
    logic [63:0] m_write_data;
    assign m_arready    = sel ? e_arready    : b_arready;
    assign m_rvalid     = sel ? e_rvalid     : b_rvalid;
    assign m_rdata      = sel ? e_rdata      : b_rdata;
    assign m_rresp      = sel ? e_rresp      : b_rresp;
    assign m_awready    = sel ? e_awready    : b_awready;
    assign m_wready     = sel ? e_wready     : b_wready;
    assign m_bvalid     = sel ? e_bvalid     : b_bvalid;
    assign m_bresp      = sel ? e_bresp      : b_bresp;
    assign m_read_en    = sel ? e_read_en    : b_read_en;
    assign m_write_en   = sel ? e_write_en   : b_write_en;
    assign m_write_data = sel ? e_write_data : b_write_data;

    logic [106:0] b_all, e_all;
    assign b_all = {b_arready, b_rdata, b_rresp, b_rvalid, b_awready, b_wready, b_bresp, b_bvalid,
                    b_read_en, b_write_en, b_write_data};
    assign e_all = {e_arready, e_rdata, e_rresp, e_rvalid, e_awready, e_wready, e_bresp, e_bvalid,
                    e_read_en, e_write_en, e_write_data};

    int          n_chk = 0, n_pass = 0;
    int          we_cnt = 0, re_cnt = 0;
    logic [63:0] push_log[$];
    logic [31:0] pop_q[$];
    logic [31:0] rd_next;

    // strobe monitor for the selected instance
    always @(posedge clk) begin
        if (m_write_en) begin
            we_cnt++;
            push_log.push_back(m_write_data);
        end
        if (m_read_en) re_cnt++;
    end

    // pop FIFO model: popped word is visible only in the cycle after read_en, junk otherwise
    always @(posedge clk) begin
        if (m_read_en) rd_next = (pop_q.size() > 0) ? pop_q.pop_front() : 32'hDEAD_0000;
        else           rd_next = $urandom;
        #1 read_data = rd_next;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit s);
        sel = s;
        arestn = 1'b0;
        {arvalid, rready, awvalid, wvalid, bready, full} = '0;
        empty = 1'b1;
        pop_q.delete();
        repeat (2) tick();
        arestn = 1'b1;
        tick();
        we_cnt = 0;
        re_cnt = 0;
        push_log.delete();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int aw_dly,
                            input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        resp = 2'bxx;
        awaddr = a;
        wdata = d;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = (cyc >= aw_dly) && !aw_done;
            wvalid  = (cyc >= w_dly) && !w_done;
            aw_hs = awvalid && m_awready;
            w_hs  = wvalid && m_wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
            if (w_done && !aw_done) begin
                n_chk++;
                if ({m_awready, m_wready} !== 2'b10)
                    $display("FAIL w_first_ready got=%b exp=10", {m_awready, m_wready});
                else n_pass++;
            end
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            n_chk++;
            $display("FAIL write_handshake_timeout got aw=%0b w=%0b exp both", aw_done, w_done);
            return;
        end
        cyc = 0;
        while (!m_bvalid && cyc < 60) begin
            tick();
            cyc++;
        end
        if (!m_bvalid) begin
            n_chk++;
            $display("FAIL bvalid_timeout got bvalid=0 exp 1");
            return;
        end
        resp = m_bresp;
        repeat (b_dly) tick();
        n_chk++;
        if (m_bvalid !== 1'b1 || m_bresp !== resp)
            $display("FAIL bresp_stable got=%b/%b exp=1/%b", m_bvalid, m_bresp, resp);
        else n_pass++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int r_dly, output logic [31:0] data,
                           output logic [1:0] resp);
        bit hs = 0;
        int cyc = 0;
        data = 'x;
        resp = 2'bxx;
        araddr = a;
        arvalid = 1'b1;
        while (!hs && cyc < 40) begin
            hs = m_arready;
            tick();
            cyc++;
        end
        arvalid = 1'b0;
        cyc = 0;
        while (!m_rvalid && cyc < 60) begin
            tick();
            cyc++;
        end
        if (!hs || !m_rvalid) begin
            n_chk++;
            $display("FAIL read_timeout got ar_hs=%0b rvalid=%0b exp 1/1", hs, m_rvalid);
            return;
        end
        data = m_rdata;
        resp = m_rresp;
        repeat (r_dly) begin
            tick();
            n_chk++;
            if (m_rvalid !== 1'b1 || m_rdata !== data || m_rresp !== resp)
                $display("FAIL rdata_stable got=%b/%h/%b exp=1/%h/%b", m_rvalid, m_rdata, m_rresp, data, resp);
            else n_pass++;
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        n_chk++;
        if (m_rvalid !== 1'b0) $display("FAIL rvalid_drop got=%b exp=0", m_rvalid);
        else n_pass++;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        arestn = 1'b0;
        #3;
        n_chk++;
        if (b_all !== '0) $display("FAIL reset_outputs_blk got=%h exp=0", b_all);
        else n_pass++;
        n_chk++;
        if (e_all !== '0) $display("FAIL reset_outputs_err got=%h exp=0", e_all);
        else n_pass++;
        tick();
        arestn = 1'b1;
        tick();
        n_chk++;
        if ({b_awready, b_wready, b_arready, b_bvalid, b_rvalid} !== 5'b11100)
            $display("FAIL reset_release_blk got=%b exp=11100", {b_awready, b_wready, b_arready, b_bvalid, b_rvalid});
        else n_pass++;
        n_chk++;
        if ({e_awready, e_wready, e_arready, e_bvalid, e_rvalid} !== 5'b11100)
            $display("FAIL reset_release_err got=%b exp=11100", {e_awready, e_wready, e_arready, e_bvalid, e_rvalid});
        else n_pass++;
    endtask

    task automatic test_write_same_cycle();
        apply_reset(1'b0);
        bready = 1'b1;
        awaddr = 32'hA5A5A5A5;
        wdata = 32'hB5B5B5B5;
        awvalid = 1'b1;
        wvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b0;
        n_chk++;
        if ({m_awready, m_wready, m_write_en} !== 3'b000)
            $display("FAIL same_ready_drop got=%b exp=000", {m_awready, m_wready, m_write_en});
        else n_pass++;
        tick();
        n_chk++;
        if (m_write_en !== 1'b1 || m_write_data !== 64'hA5A5A5A5_B5B5B5B5)
            $display("FAIL same_push got=%b/%h exp=1/a5a5a5a5b5b5b5b5", m_write_en, m_write_data);
        else n_pass++;
        tick();
        n_chk++;
        if ({m_write_en, m_bvalid, m_bresp} !== 4'b0100)
            $display("FAIL same_bresp got=%b exp=0100", {m_write_en, m_bvalid, m_bresp});
        else n_pass++;
        tick();
        bready = 1'b0;
        n_chk++;
        if ({m_bvalid, m_awready, m_wready} !== 3'b011)
            $display("FAIL same_rearm got=%b exp=011", {m_bvalid, m_awready, m_wready});
        else n_pass++;
        n_chk++;
        if (we_cnt !== 1) $display("FAIL same_push_count got=%0d exp=1", we_cnt);
        else n_pass++;
    endtask

    task automatic test_write_orders();
        logic [31:0] a, d;
        logic [1:0]  resp;
        logic [63:0] exp_q[$];
        apply_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            d = $urandom;
            exp_q.push_back({a, d});
            if (i == 0) do_write(a, d, 3, 0, 0, resp);
            else do_write(a, d, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), resp);
            n_chk++;
            if (resp !== 2'b00) $display("FAIL order_bresp[%0d] got=%b exp=00", i, resp);
            else n_pass++;
        end
        n_chk++;
        if (push_log.size() !== exp_q.size()) $display("FAIL order_push_count got=%0d exp=%0d", push_log.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < push_log.size(); i++) begin
            n_chk++;
            if (push_log[i] !== exp_q[i]) $display("FAIL order_push_data[%0d] got=%h exp=%h", i, push_log[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_full_policy();
        logic [1:0] resp;
        logic [1:0] exp_resp;
        int         exp_pushes;
        apply_reset(1'b0);
        full = 1'b1;
        fork
            do_write(32'h0000_1234, 32'h5678_9ABC, 0, 0, 0, resp);
            begin
                repeat (5) tick();
                n_chk++;
                if (we_cnt !== 0 || m_write_en !== 1'b0) $display("FAIL full_block_nopush got=%0d exp=0", we_cnt);
                else n_pass++;
                full = 1'b0;
                tick();
                n_chk++;
                if (m_write_en !== 1'b1 || m_write_data !== 64'h0000_1234_5678_9ABC)
                    $display("FAIL full_release_push got=%b/%h exp=1/0000123456789abc", m_write_en, m_write_data);
                else n_pass++;
            end
        join
        n_chk++;
        if (resp !== 2'b00 || we_cnt !== 1) $display("FAIL full_block_resp got=%b/%0d exp=00/1", resp, we_cnt);
        else n_pass++;

        apply_reset(1'b1);
        full = 1'b1;
        do_write(32'h0000_4321, 32'h0BAD_F00D, 0, 0, 0, resp);
        n_chk++;
        if (resp !== 2'b10 || we_cnt !== 0) $display("FAIL full_err_resp got=%b/%0d exp=10/0", resp, we_cnt);
        else n_pass++;

        exp_pushes = 0;
        for (int i = 0; i < 6; i++) begin
            full = $urandom_range(0, 1);
            exp_resp = full ? 2'b10 : 2'b00;
            if (!full) exp_pushes++;
            do_write($urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 0, resp);
            n_chk++;
            if (resp !== exp_resp) $display("FAIL full_err_rand[%0d] got=%b exp=%b", i, resp, exp_resp);
            else n_pass++;
        end
        full = 1'b0;
        n_chk++;
        if (we_cnt !== exp_pushes) $display("FAIL full_err_push_count got=%0d exp=%0d", we_cnt, exp_pushes);
        else n_pass++;
    endtask

    task automatic test_read_pop();
        logic [31:0] data;
        logic [1:0]  resp;
        apply_reset(1'b0);
        empty = 1'b0;
        pop_q.push_back(32'hCAFEF00D);
        do_read(32'h0, 4, data, resp);
        n_chk++;
        if (data !== 32'hCAFEF00D || resp !== 2'b00 || re_cnt !== 1)
            $display("FAIL read_pop got=%h/%b/%0d exp=cafef00d/00/1", data, resp, re_cnt);
        else n_pass++;
    endtask

    task automatic test_status();
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] exp_d;
        apply_reset(1'b0);
        full = 1'b1;
        empty = 1'b0;
        do_read(STATUS, 0, data, resp);
        n_chk++;
        if (data !== 32'd2 || resp !== 2'b00 || re_cnt !== 0)
            $display("FAIL status_full got=%h/%b/%0d exp=2/00/0", data, resp, re_cnt);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            full = $urandom_range(0, 1);
            empty = $urandom_range(0, 1);
            exp_d = 32'(full) * 2 + 32'(empty);
            do_read(STATUS, $urandom_range(0, 2), data, resp);
            n_chk++;
            if (data !== exp_d || resp !== 2'b00) $display("FAIL status_rand[%0d] got=%h/%b exp=%h/00", i, data, resp, exp_d);
            else n_pass++;
        end
        full = 1'b0;
        n_chk++;
        if (re_cnt !== 0) $display("FAIL status_no_pop got=%0d exp=0", re_cnt);
        else n_pass++;
    endtask

    task automatic test_empty_policy();
        logic [31:0] data, a, v, exp_d;
        logic [1:0]  resp, exp_r;
        int          exp_pops, mode;
        apply_reset(1'b0);
        empty = 1'b1;
        pop_q.push_back(32'h1357_9BDF);
        fork
            do_read(32'h40, 0, data, resp);
            begin
                repeat (6) tick();
                n_chk++;
                if (re_cnt !== 0 || m_rvalid !== 1'b0) $display("FAIL empty_block_nopop got=%0d/%b exp=0/0", re_cnt, m_rvalid);
                else n_pass++;
                empty = 1'b0;
            end
        join
        n_chk++;
        if (data !== 32'h1357_9BDF || resp !== 2'b00) $display("FAIL empty_block_data got=%h/%b exp=13579bdf/00", data, resp);
        else n_pass++;

        apply_reset(1'b1);
        empty = 1'b1;
        do_read(32'h0000_0010, 0, data, resp);
        n_chk++;
        if (data !== 32'h0 || resp !== 2'b10 || re_cnt !== 0)
            $display("FAIL empty_err got=%h/%b/%0d exp=0/10/0", data, resp, re_cnt);
        else n_pass++;

        exp_pops = 0;
        for (int i = 0; i < 10; i++) begin
            mode = $urandom_range(0, 2);
            a = $urandom;
            if (a == STATUS) a = a ^ 32'h1;
            full = $urandom_range(0, 1);
            if (mode == 0) begin
                empty = $urandom_range(0, 1);
                a = STATUS;
                exp_d = 32'(full) * 2 + 32'(empty);
                exp_r = 2'b00;
            end else if (mode == 1) begin
                v = $urandom;
                pop_q.push_back(v);
                empty = 1'b0;
                exp_d = v;
                exp_r = 2'b00;
                exp_pops++;
            end else begin
                empty = 1'b1;
                exp_d = 32'h0;
                exp_r = 2'b10;
            end
            do_read(a, $urandom_range(0, 2), data, resp);
            n_chk++;
            if (data !== exp_d || resp !== exp_r) $display("FAIL read_rand[%0d] got=%h/%b exp=%h/%b", i, data, resp, exp_d, exp_r);
            else n_pass++;
        end
        full = 1'b0;
        n_chk++;
        if (re_cnt !== exp_pops) $display("FAIL read_rand_pops got=%0d exp=%0d", re_cnt, exp_pops);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        apply_reset(1'b0);
        full = 1'b1;
        empty = 1'b0;
        pop_q.push_back(32'h2468_ACE0);
        awaddr = 32'h11;
        wdata = 32'h22;
        araddr = 32'h33;
        awvalid = 1'b1;
        wvalid = 1'b1;
        arvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b0;
        arvalid = 1'b0;
        tick();
        n_chk++;
        if (m_read_en !== 1'b1 || m_write_en !== 1'b0) $display("FAIL midflight_setup got=%b/%b exp=1/0", m_read_en, m_write_en);
        else n_pass++;
        #3 arestn = 1'b0;
        #1;
        n_chk++;
        if (b_all !== '0) $display("FAIL midflight_reset_outputs got=%h exp=0", b_all);
        else n_pass++;
        tick();
        tick();
        pop_q.delete();
        full = 1'b0;
        arestn = 1'b1;
        we_cnt = 0;
        re_cnt = 0;
        tick();
        n_chk++;
        if ({m_awready, m_wready, m_arready} !== 3'b111) $display("FAIL midflight_ready got=%b exp=111", {m_awready, m_wready, m_arready});
        else n_pass++;
        repeat (5) tick();
        n_chk++;
        if (we_cnt !== 0 || re_cnt !== 0 || m_bvalid !== 1'b0 || m_rvalid !== 1'b0)
            $display("FAIL midflight_stray got=%0d/%0d/%b/%b exp=0/0/0/0", we_cnt, re_cnt, m_bvalid, m_rvalid);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_same_cycle();
        test_write_orders();
        test_full_policy();
        test_read_pop();
        test_status();
        test_empty_policy();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
